// File: rtl/io_hub_hs_if.sv
// Requester-side bus of the MMIO hub: req/ack handshake with registered read return.
interface io_hub_hs_if;
  logic        soc_req;
  logic        soc_we;
  logic [31:0] soc_addr;
  logic [31:0] soc_wdata;
  logic [31:0] soc_rdata;
  logic        soc_ack;
  logic        soc_err;

  // CPU data-memory port side
  modport master (
    output soc_req, soc_we, soc_addr, soc_wdata,
    input  soc_rdata, soc_ack, soc_err
  );

  // Hub side
  modport slave (
    input  soc_req, soc_we, soc_addr, soc_wdata,
    output soc_rdata, soc_ack, soc_err
  );
endinterface

// File: rtl/io_hub_hs.sv
// Handshaked MMIO hub: decodes a base-aligned window into one-hot device
// requests, waits for the selected device's ack with a timeout, and returns a
// registered response with error flag. Errors are counted (saturating) and the
// address of the most recent failing access is kept.
module io_hub_hs #(
  parameter int unsigned N_DEV     = 8,
  parameter int unsigned DEV_AW    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7800,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  io_hub_hs_if.slave            soc,
  output logic [N_DEV-1:0]      dev_req,
  output logic                  dev_we,
  output logic [DEV_AW-1:0]     dev_addr,
  output logic [31:0]           dev_wdata,
  input  logic [N_DEV*32-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]      dev_ack,
  output logic [7:0]            err_cnt,
  output logic [31:0]           err_addr
);

  localparam int unsigned SW       = $clog2(N_DEV);
  localparam int unsigned HI       = DEV_AW + SW;
  localparam int unsigned CW       = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [7:0]    ERR_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     idx_q, idx_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [N_DEV-1:0]  dev_req_q, dev_req_d;
  logic              soc_ack_q, soc_ack_d;
  logic              soc_err_q, soc_err_d;
  logic [31:0]       soc_rdata_q, soc_rdata_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic              hit_c;
  logic [SW-1:0]     slot_c;
  logic              sel_ack_c;
  logic [31:0]       sel_rdata_c;
  logic              last_c;
  logic [7:0]        err_inc_c;

  // Window decode of the incoming request
  assign hit_c  = (soc.soc_addr[31:HI] == BASE_ADDR[31:HI]);
  assign slot_c = soc.soc_addr[HI-1:DEV_AW];
  assign last_c = (cnt_q == CNT_LAST);
  assign err_inc_c = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + 8'd1;

  // Select ack and read data of the latched slot; other slots are ignored
  always_comb begin
    sel_ack_c   = 1'b0;
    sel_rdata_c = 32'd0;
    for (int i = 0; i < N_DEV; i++) begin
      if (idx_q == SW'(i)) begin
        sel_ack_c   = dev_ack[i];
        sel_rdata_c = dev_rdata[i*32 +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (soc.soc_req) state_d = hit_c ? S_ACCESS : S_RESP;
      end
      S_ACCESS: begin
        if (sel_ack_c || last_c) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dev_req_d   = dev_req_q;
    soc_ack_d   = 1'b0;
    soc_err_d   = 1'b0;
    soc_rdata_d = 32'd0;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (soc.soc_req) begin
          if (hit_c) begin
            idx_d     = slot_c;
            we_d      = soc.soc_we;
            addr_d    = soc.soc_addr;
            wdata_d   = soc.soc_wdata;
            cnt_d     = '0;
            dev_req_d = N_DEV'(1) << slot_c;
          end else begin
            soc_ack_d  = 1'b1;
            soc_err_d  = 1'b1;
            err_cnt_d  = err_inc_c;
            err_addr_d = soc.soc_addr;
          end
        end
      end
      S_ACCESS: begin
        if (sel_ack_c) begin
          // A late ack in the last timeout cycle still completes normally
          dev_req_d   = '0;
          soc_ack_d   = 1'b1;
          soc_rdata_d = we_q ? 32'd0 : sel_rdata_c;
        end else if (last_c) begin
          dev_req_d  = '0;
          soc_ack_d  = 1'b1;
          soc_err_d  = 1'b1;
          err_cnt_d  = err_inc_c;
          err_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  dev_req_d = '0;
      default: dev_req_d = '0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dev_req_q   <= '0;
      soc_ack_q   <= 1'b0;
      soc_err_q   <= 1'b0;
      soc_rdata_q <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dev_req_q   <= dev_req_d;
      soc_ack_q   <= soc_ack_d;
      soc_err_q   <= soc_err_d;
      soc_rdata_q <= soc_rdata_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign dev_req       = dev_req_q;
  assign dev_we        = we_q;
  assign dev_addr      = addr_q[DEV_AW-1:0];
  assign dev_wdata     = wdata_q;
  assign soc.soc_ack   = soc_ack_q;
  assign soc.soc_err   = soc_err_q;
  assign soc.soc_rdata = soc_rdata_q;
  assign err_cnt       = err_cnt_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_io_hub_hs.sv
// Randomized bench for io_hub_hs against a transaction-level reference model.
module tb_io_hub_hs;
  localparam int unsigned N_DEV   = 8;
  localparam int unsigned DEV_AW  = 8;
  localparam logic [31:0] BASE    = 32'h0000_7800;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_hub_hs_if soc ();
  logic [N_DEV-1:0]    dev_req;
  logic                dev_we;
  logic [DEV_AW-1:0]   dev_addr;
  logic [31:0]         dev_wdata;
  logic [N_DEV*32-1:0] dev_rdata;
  logic [N_DEV-1:0]    dev_ack;
  logic [7:0]          err_cnt;
  logic [31:0]         err_addr;

  io_hub_hs #(.N_DEV(N_DEV), .DEV_AW(DEV_AW), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .soc(soc),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack), .err_cnt(err_cnt), .err_addr(err_addr)
  );

  // Second build: 16 slots, 4 KB window at 0x7000
  io_hub_hs_if soc2 ();
  logic [15:0]    dev_req2;
  logic           dev_we2;
  logic [7:0]     dev_addr2;
  logic [31:0]    dev_wdata2;
  logic [16*32-1:0] dev_rdata2;
  logic [15:0]    dev_ack2;
  logic [7:0]     err_cnt2;
  logic [31:0]    err_addr2;

  io_hub_hs #(.N_DEV(16), .DEV_AW(8), .BASE_ADDR(32'h0000_7000), .TIMEOUT(15)) dut16 (
    .clk(clk), .rst_n(rst_n), .soc(soc2),
    .dev_req(dev_req2), .dev_we(dev_we2), .dev_addr(dev_addr2), .dev_wdata(dev_wdata2),
    .dev_rdata(dev_rdata2), .dev_ack(dev_ack2), .err_cnt(err_cnt2), .err_addr(err_addr2)
  );

  int n_vec = 0;
  int n_err = 0;
  int m_err_cnt = 0;
  logic [31:0] m_err_addr = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access; ack_after = wait cycles before dev ack (<0: never acks)
  task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                            input int ack_after, input logic [31:0] rd, input logic [7:0] extra);
    bit hit;
    int slot, exp_dreq, exp_lat, cyc, dreq_cyc;
    bit exp_err, got;
    logic [31:0] exp_rdata;
    logic [7:0]  onehot, other;

    hit  = (addr / 32'd2048) == (BASE / 32'd2048);
    slot = int'((addr / 32'd256) % 32'd8);
    onehot = 8'd1 << slot;
    other  = extra & ~onehot;
    if (!hit) begin
      exp_dreq = 0; exp_lat = 1; exp_err = 1'b1; exp_rdata = 32'd0;
    end else if (ack_after >= 0 && ack_after < int'(TIMEOUT)) begin
      exp_dreq = ack_after + 1; exp_lat = exp_dreq + 1; exp_err = 1'b0;
      exp_rdata = we ? 32'd0 : rd;
    end else begin
      exp_dreq = int'(TIMEOUT); exp_lat = exp_dreq + 1; exp_err = 1'b1; exp_rdata = 32'd0;
    end
    if (exp_err) begin
      if (m_err_cnt < 255) m_err_cnt++;
      m_err_addr = addr;
    end

    @(negedge clk);
    for (int i = 0; i < int'(N_DEV); i++) dev_rdata[i*32 +: 32] = $urandom;
    dev_rdata[slot*32 +: 32] = rd;
    soc.soc_req = 1'b1; soc.soc_we = we; soc.soc_addr = addr; soc.soc_wdata = wd;
    cyc = 0; dreq_cyc = 0; got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      dev_ack = '0;
      if (dev_req != 8'd0) begin
        dreq_cyc++;
        check_eq("dev_req_onehot", 32'(dev_req), 32'(onehot));
        check_eq("dev_we", 32'(dev_we), 32'(we));
        check_eq("dev_addr", 32'(dev_addr), addr & 32'hFF);
        check_eq("dev_wdata", dev_wdata, wd);
        if (ack_after >= 0 && dreq_cyc - 1 == ack_after) dev_ack = onehot;
        dev_ack = dev_ack | other;
      end else if (cyc == 1) begin
        dev_ack = other;
      end
      if (soc.soc_ack) begin
        got = 1'b1;
        soc.soc_req = 1'b0;
        dev_ack = '0;
        check_eq("latency", 32'(cyc), 32'(exp_lat));
        check_eq("soc_err", 32'(soc.soc_err), 32'(exp_err));
        check_eq("soc_rdata", soc.soc_rdata, exp_rdata);
        check_eq("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
        check_eq("err_addr", err_addr, m_err_addr);
      end
    end
    if (!got) check_eq("ack_timeout", 32'(cyc), 32'(exp_lat));
    check_eq("dev_req_cycles", 32'(dreq_cyc), 32'(exp_dreq));
    soc.soc_req = 1'b0;
    dev_ack = '0;
    @(posedge clk); #1;
    check_eq("ack_single", 32'(soc.soc_ack), 32'd0);
    check_eq("dev_req_idle", 32'(dev_req), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int wait_c;
    soc.soc_req = 1'b0; soc.soc_we = 1'b0; soc.soc_addr = '0; soc.soc_wdata = '0;
    soc2.soc_req = 1'b0; soc2.soc_we = 1'b0; soc2.soc_addr = '0; soc2.soc_wdata = '0;
    dev_rdata = '0; dev_ack = '0; dev_rdata2 = '0; dev_ack2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_dev_req", 32'(dev_req), 32'd0);
    check_eq("rst_soc_ack", 32'(soc.soc_ack), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_dev_wdata", dev_wdata, 32'd0);
    rst_n = 1'b1;

    // Directed scenarios
    run_access(32'h0000_7904, 1'b0, 32'h0, 0, 32'h1234_5678, 8'h00);
    run_access(32'h0000_7F10, 1'b1, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 8'h00);
    run_access(32'h0000_1000, 1'b0, 32'h0, 0, 32'h0, 8'hFF);
    run_access(32'h0000_7B20, 1'b0, 32'h0, -1, 32'h5555_AAAA, 8'h00);
    run_access(32'h0000_7B24, 1'b0, 32'h0, 14, 32'h0BAD_F00D, 8'h00);
    run_access(32'h0000_7A08, 1'b0, 32'h0, 2, 32'h2222_2222, 8'h20);

    // Randomized mix of hits, misses, timeouts and stray acks
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : (BASE | (32'($urandom) & 32'h7FF));
      wait_c = int'($urandom_range(0, 18)) - 1;
      run_access(a, 1'($urandom), $urandom, wait_c, $urandom, 8'($urandom));
    end

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      a = $urandom;
      if ((a / 32'd2048) == (BASE / 32'd2048)) a = a ^ 32'h8000_0000;
      run_access(a, 1'($urandom), $urandom, 0, 32'h0, 8'h00);
    end
    check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset in the middle of an access
    @(negedge clk);
    soc.soc_req = 1'b1; soc.soc_we = 1'b1; soc.soc_addr = 32'h0000_7B00; soc.soc_wdata = 32'h1111_2222;
    repeat (6) @(posedge clk);
    #2;
    check_eq("pre_rst_dev_req", 32'(dev_req), 32'h08);
    rst_n = 1'b0;
    #1;
    check_eq("async_dev_req", 32'(dev_req), 32'd0);
    check_eq("async_dev_we", 32'(dev_we), 32'd0);
    check_eq("async_dev_addr", 32'(dev_addr), 32'd0);
    check_eq("async_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("async_err_addr", err_addr, 32'd0);
    check_eq("async_soc_ack", 32'(soc.soc_ack), 32'd0);
    soc.soc_req = 1'b0;
    m_err_cnt = 0; m_err_addr = 32'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check_eq("no_ack_after_rst", 32'(soc.soc_ack), 32'd0);
    end
    run_access(32'h0000_7B00, 1'b0, 32'h0, 1, 32'h7777_0001, 8'h00);
    run_access(32'h0000_0004, 1'b0, 32'h0, 0, 32'h0, 8'h00);

    // 16-slot build: 0x7F00 decodes to slot 15
    @(negedge clk);
    dev_rdata2[15*32 +: 32] = 32'hF00D_0015;
    soc2.soc_req = 1'b1; soc2.soc_we = 1'b0; soc2.soc_addr = 32'h0000_7F00;
    @(posedge clk); #1;
    check_eq("n16_dev_req", 32'(dev_req2), 32'h0000_8000);
    soc2.soc_req = 1'b0;
    dev_ack2 = 16'h8000;
    @(posedge clk); #1;
    dev_ack2 = '0;
    check_eq("n16_ack", 32'(soc2.soc_ack), 32'd1);
    check_eq("n16_rdata", soc2.soc_rdata, 32'hF00D_0015);
    check_eq("n16_err", 32'(soc2.soc_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
